pic_pc_stack: RTL

Parametrised program-sequencing block for the pic core: it generates the instruction-cycle phase strobes and owns the program counter together with a hardware return stack. It adds CALL/RETURN, SKIP, GOTO, a hold input, and stack status flags that the current fixed-width counter and clock generator do not provide. It sits between the decode stage, which supplies the `op` and `target` inputs, and the program ROM, which is addressed by `counter`.

---
 rtl/pic_pc_stack.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pic_pc_stack.sv
// pic_pc_stack: instruction-cycle phase generator, program counter and
// circular hardware return stack for the pic core. Every architectural
// update (counter, stack, depth, tos, sticky flags) happens on the commit edge.
// The commit edge is the last phase of an instruction cycle with hold low.
module pic_pc_stack #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 8,
    parameter int PHASES      = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             hold,
    input  logic [2:0]                       op,
    input  logic [PC_WIDTH-1:0]              target,
    output logic [PHASES-1:0]                phase,
    output logic                             cycle_end,
    output logic [PC_WIDTH-1:0]              counter,
    output logic [PC_WIDTH-1:0]              tos,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    localparam logic [2:0] OP_SKIP   = 3'b001;
    localparam logic [2:0] OP_GOTO   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RETURN = 3'b100;

    // Phase ring
    logic [PHASES-1:0]   phase_reg;
    logic [PHASES-1:0]   phase_next;
    logic                commit;

    // Program counter and stack state
    logic [PC_WIDTH-1:0] counter_reg;
    logic [PC_WIDTH-1:0] counter_next;
    logic [PC_WIDTH-1:0] tos_reg;
    logic [PTR_W-1:0]    ptr_reg;
    logic [DEPTH_W-1:0]  depth_reg;
    logic                overflow_reg;
    logic                underflow_reg;
    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    // Decoded per-instruction actions
    logic                push;
    logic                pop;
    logic                ret_empty;
    logic [PC_WIDTH-1:0] push_data;
    logic [PTR_W-1:0]    below2_addr;

    // One-bit left rotation of the phase ring, wrapping the top bit to bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < PHASES; gi++) begin : g_rot
            if (gi == 0) begin : g_wrap
                assign phase_next[gi] = phase_reg[PHASES-1];
            end else begin : g_shift
                assign phase_next[gi] = phase_reg[gi-1];
            end
        end
    endgenerate

    assign commit = phase_reg[PHASES-1] & ~hold;

    // Phase register: starts at phase[0], rotates every clock unless held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_reg <= {{(PHASES-1){1'b0}}, 1'b1};
        end else if (!hold) begin
            phase_reg <= phase_next;
        end
    end

    assign push_data   = counter_reg + PC_WIDTH'(1);
    assign below2_addr = ptr_reg - PTR_W'(2);

    // Opcode decode: next counter value and stack action for this instruction.
    always_comb begin
        counter_next = counter_reg + PC_WIDTH'(1);
        push         = 1'b0;
        pop          = 1'b0;
        ret_empty    = 1'b0;
        case (op)
            OP_SKIP: counter_next = counter_reg + PC_WIDTH'(2);
            OP_GOTO: counter_next = target;
            OP_CALL: begin
                push         = 1'b1;
                counter_next = target;
            end
            OP_RETURN: begin
                if (depth_reg == '0) begin
                    ret_empty    = 1'b1;
                    counter_next = '0;
                end else begin
                    pop          = 1'b1;
                    counter_next = tos_reg;
                end
            end
            default: counter_next = counter_reg + PC_WIDTH'(1);
        endcase
    end

    // Program counter: updated only on the commit edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_reg <= '0;
        end else if (commit) begin
            counter_reg <= counter_next;
        end
    end

    // Stack pointer, depth and sticky error flags.
    // A push onto a full stack advances the pointer over the oldest entry
    // while depth saturates; a pop of an empty stack touches only underflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg       <= '0;
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (commit) begin
            if (push) begin
                ptr_reg <= ptr_reg + PTR_W'(1);
                if (depth_reg == DEPTH_MAX) begin
                    overflow_reg <= 1'b1;
                end else begin
                    depth_reg <= depth_reg + DEPTH_W'(1);
                end
            end else if (pop) begin
                ptr_reg   <= ptr_reg - PTR_W'(1);
                depth_reg <= depth_reg - DEPTH_W'(1);
            end else if (ret_empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // Stack storage write: only on a committed CALL, never during reset.
    always_ff @(posedge clk) begin
        if (reset && commit && push) begin
            stack_mem[ptr_reg] <= push_data;
        end
    end

    // Registered top-of-stack. A push shows the new return address; a pop
    // reads the entry two below the current pointer, which becomes the new
    // top. This keeps the stack read synchronous and off the counter path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tos_reg <= '0;
        end else if (commit) begin
            if (push) begin
                tos_reg <= push_data;
            end else if (pop) begin
                if (depth_reg > DEPTH_W'(1)) begin
                    tos_reg <= stack_mem[below2_addr];
                end else begin
                    tos_reg <= '0;
                end
            end
        end
    end

    assign phase       = phase_reg;
    assign cycle_end   = phase_reg[PHASES-1];
    assign counter     = counter_reg;
    assign tos         = tos_reg;
    assign depth       = depth_reg;
    assign stack_full  = (depth_reg == DEPTH_MAX);
    assign stack_empty = (depth_reg == '0);
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule
